// File: rtl/boot_pkg.sv
// boot_pkg: state encoding and default widths shared by the boot sequencer slice
package boot_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 8;
    localparam int CNT_W_DEF    = 16;
    localparam int RST_HOLD_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RESET = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/boot_sequencer_if.sv
// boot_sequencer_if: instruction stream in, instruction memory write port out
interface boot_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter with sync clear and enable, sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst || clr)
            count <= '0;
        else if (en && !(&count))
            count <= count + W'(1);
    end
endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads instruction memory from a stream, then sequences core reset/enable
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int RST_HOLD = RST_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    boot_sequencer_if.slave  bus,
    input  logic             start,
    input  logic [ADDR_W:0]  load_len,
    input  logic [CNT_W-1:0] run_limit,
    input  logic             halt_req,
    output logic             core_rst_n,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int HW = $clog2(RST_HOLD + 1);

    state_t            state, nxt;
    logic [ADDR_W:0]   len_q, wcnt;
    logic [CNT_W-1:0]  lim_q;
    logic [HW-1:0]     hold_cnt;
    logic              released;
    logic              hs, last_word, hold_end, run_end, begin_seq;

    assign hs        = bus.s_valid && bus.s_ready;
    assign last_word = wcnt == len_q - (ADDR_W+1)'(1);
    assign hold_end  = hold_cnt == HW'(RST_HOLD - 1);
    assign run_end   = lim_q != '0 && cycle_count == lim_q - CNT_W'(1);
    assign begin_seq = state == IDLE && start;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (load_len != '0 ? LOAD : RESET) : IDLE;
            LOAD:    nxt = halt_req ? DONE : (hs && last_word) ? RESET : LOAD;
            RESET:   nxt = halt_req ? DONE : hold_end ? RUN : RESET;
            RUN:     nxt = (halt_req || run_end) ? DONE : RUN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // After a completed sequence the core stays out of reset so its state can be read back
    assign bus.s_ready = state == LOAD;
    assign core_en     = state == RUN;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign core_rst_n  = state == RUN || state == DONE || (state == IDLE && released);

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            len_q          <= '0;
            lim_q          <= '0;
            wcnt           <= '0;
            hold_cnt       <= '0;
            aborted        <= 1'b0;
            released       <= 1'b0;
        end else begin
            bus.imem_we <= hs;
            if (hs) begin
                bus.imem_addr  <= wcnt[ADDR_W-1:0];
                bus.imem_wdata <= bus.s_data;
                wcnt           <= wcnt + (ADDR_W+1)'(1);
            end
            hold_cnt <= state == RESET ? hold_cnt + HW'(1) : '0;
            if (begin_seq) begin
                len_q    <= load_len;
                lim_q    <= run_limit;
                wcnt     <= '0;
                aborted  <= 1'b0;
                released <= 1'b0;
            end
            if ((state == LOAD || state == RESET) && halt_req)
                aborted <= 1'b1;
            if (state == DONE)
                released <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (begin_seq),
        .en    (state == RUN),
        .count (cycle_count)
    );
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: table-driven load/run scenarios plus reset and restart corner cases
module tb_boot_sequencer;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int RH = 2;

    typedef struct {
        int len;
        int lim;
        int gap;
        int halt_hs;
        int halt_run;
        int start_run;
        int exp_wr;
        int exp_en;
        int exp_cnt;
        int exp_ab;
        int exp_rh;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic [AW:0]   load_len = '0;
    logic [CW-1:0] run_limit = '0;
    logic          core_rst_n, core_en, busy, done, aborted;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] words [4];
    vec_t          vecs [7];
    int            checks = 0;
    int            failures = 0;

    boot_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    boot_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RST_HOLD(RH)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .start       (start),
        .load_len    (load_len),
        .run_limit   (run_limit),
        .halt_req    (halt_req),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, 32'(bus.s_ready), 0);
        chk({tag, "_we"}, 32'(bus.imem_we), 0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 0);
        chk({tag, "_wdata"}, bus.imem_wdata, 0);
        chk({tag, "_rstn"}, 32'(core_rst_n), 0);
        chk({tag, "_en"}, 32'(core_en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_aborted"}, 32'(aborted), 0);
        chk({tag, "_count"}, 32'(cycle_count), 0);
    endtask

    // Drives one sequence; observes at negedge, then sets inputs for the next rising edge
    task automatic run_seq(input vec_t v);
        int  hs = 0, lc = 0, en = 0, rl = 0, wr = 0, dn = 0;
        bit  prev_hs = 1'b0, fin = 1'b0;
        @(negedge clk);
        load_len  = (AW+1)'(v.len);
        run_limit = CW'(v.lim);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 300 && !fin; t++) begin
            chk("we_only_after_hs", 32'(bus.imem_we), 32'(prev_hs));
            if (bus.imem_we) begin
                chk("imem_addr", 32'(bus.imem_addr), 32'(wr));
                chk("imem_wdata", bus.imem_wdata, words[wr % 4]);
                wr++;
            end
            if (core_en) en++;
            if (busy && !bus.s_ready && !core_en && !done) begin
                rl++;
                chk("reset_rstn", 32'(core_rst_n), 0);
            end
            if (done) begin
                dn++;
                fin = 1'b1;
                chk("done_count", 32'(cycle_count), 32'(v.exp_cnt));
                chk("done_aborted", 32'(aborted), 32'(v.exp_ab));
                chk("done_rstn", 32'(core_rst_n), 1);
                chk("done_en", 32'(core_en), 0);
            end
            prev_hs     = 1'b0;
            bus.s_valid = 1'b0;
            halt_req    = 1'b0;
            start       = 1'b0;
            if (!fin) begin
                if (bus.s_ready) begin
                    if (hs == v.halt_hs)
                        halt_req = 1'b1;
                    else if (v.gap == 0 || lc % 3 == 0) begin
                        bus.s_valid = 1'b1;
                        bus.s_data  = words[hs % 4];
                        prev_hs     = 1'b1;
                        hs++;
                    end
                    lc++;
                end
                if (core_en && en == v.halt_run) halt_req = 1'b1;
                if (core_en && en == v.start_run) begin
                    start     = 1'b1;
                    load_len  = (AW+1)'(4);
                    run_limit = CW'(5);
                end
            end
            @(negedge clk);
        end
        chk("finished_in_budget", 32'(fin), 1);
        chk("idle_done_low", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rstn_held", 32'(core_rst_n), 1);
        chk("idle_count_held", 32'(cycle_count), 32'(v.exp_cnt));
        chk("idle_aborted", 32'(aborted), 32'(v.exp_ab));
        chk("write_total", 32'(wr), 32'(v.exp_wr));
        chk("en_cycles", 32'(en), 32'(v.exp_en));
        chk("rst_hold_cycles", 32'(rl), 32'(v.exp_rh));
        chk("done_pulses", 32'(dn), 1);
    endtask

    initial begin
        int n;
        words[0] = 32'h00500093;
        words[1] = 32'h00300113;
        words[2] = 32'h002081B3;
        words[3] = 32'h00000013;
        //          len lim gap hhs hrun srun  wr en cnt ab rh
        vecs[0] = '{4,  10, 0,  -1, -1,  -1,   4, 10, 10, 0, 2};
        vecs[1] = '{4,  10, 1,  -1, -1,  -1,   4, 10, 10, 0, 2};
        vecs[2] = '{0,  0,  0,  -1, 7,   -1,   0, 7,  7,  0, 2};
        vecs[3] = '{4,  10, 0,  2,  -1,  -1,   2, 0,  0,  1, 0};
        vecs[4] = '{0,  1,  0,  -1, 1,   -1,   0, 1,  1,  0, 2};
        vecs[5] = '{3,  3,  0,  -1, -1,  -1,   3, 3,  3,  0, 2};
        vecs[6] = '{0,  20, 0,  -1, -1,  3,    0, 20, 20, 0, 2};
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rstn_after_por", 32'(core_rst_n), 0);
        for (int i = 0; i < 7; i++) run_seq(vecs[i]);

        // Reset asserted mid-run must return everything to its reset values
        load_len  = '0;
        run_limit = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cycle_count != CW'(5) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_count5", 32'(n < 50), 1);
        chk("run_at_count5", 32'(core_en), 1);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_in_run");
        rst = 1'b1;
        @(negedge clk);
        chk("stay_idle_after_rst", 32'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
